// File: rtl/edge_event_queue.sv
// Timestamped FIFO of edge-detector pulse vectors with a sticky overflow flag.
// Define EDGE_EVENT_TSTAMP_EN to build the stamp counter and per-entry timestamp storage.
module edge_event_queue #(
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               pedge,
  input  logic                     rd_ready,
  input  logic                     ovf_clr,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic [STAMP_W-1:0]       rd_stamp,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [7:0]    dataMem [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic isEmpty, isFull, pushReq, doPop, doWrite, doDrop;

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  always_comb begin
    isEmpty  = (level_q == '0);
    isFull   = (level_q == FULL_LEVEL);
    pushReq  = (pedge != '0);
    doPop    = !isEmpty && rd_ready;
    doWrite  = pushReq && (!isFull || doPop);
    doDrop   = pushReq && isFull && !doPop;

    wrPtr_d    = doWrite ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d    = doPop   ? rdPtr_q + AW'(1) : rdPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (doWrite && !doPop) begin
      level_d = level_q + LW'(1);
    end else if (doPop && !doWrite) begin
      level_d = level_q - LW'(1);
    end

    if (doDrop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite && !rst) begin
      dataMem[wrPtr_q] <= pedge;
    end
  end

`ifdef EDGE_EVENT_TSTAMP_EN
  logic [STAMP_W-1:0] stamp_q;
  logic [STAMP_W-1:0] stampMem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_q <= '0;
    end else begin
      stamp_q <= stamp_q + STAMP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite && !rst) begin
      stampMem[wrPtr_q] <= stamp_q;
    end
  end

  assign rd_stamp = isEmpty ? '0 : stampMem[rdPtr_q];
`else
  assign rd_stamp = '0;
`endif

  // Storage is never reset, so the head is masked while nothing is stored.
  assign rd_valid = !isEmpty;
  assign rd_data  = isEmpty ? 8'h00 : dataMem[rdPtr_q];
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule
